mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped UART transmitter with a byte TX FIFO.
//
// Registers (byte offsets on addr):
//   0x0 TXDATA  W: wdata[7:0] pushed into the FIFO (wen[0]); reads 0
//   0x4 STATUS  R: {count[14:8], ovf[3], empty[2], full[1], busy[0]}
//               W: wen[0] & wdata[3] clears the sticky overflow flag
//   0x8 DIV     RW: clk cycles per bit; wen[0] -> [7:0], wen[1] -> [15:8]
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   sel, addr, wen,    bus access; sel with wen==0 is a read
//   wdata
//   rdata              registered read data, valid the cycle after a read
//   tx                 serial line, idle high (registered)
//   irq                high while the FIFO is empty and the line is idle
//
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1).
// Optional feature: define UART_TX_PARITY_EN to insert the even-parity bit.
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [3:0]  wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic [15:0]     div_lat_q, div_lat_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     div_q, div_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];

  logic        full, empty, pop, push, wr_req, rd_req, clr_req, ovf_set;
  logic [6:0]  cnt7;
  logic [31:0] status;

  // Bit-period counter reload: counts down to 0, a divisor of 0 behaves as 1.
  function automatic logic [15:0] reload(input logic [15:0] d);
    return (d == 16'd0) ? 16'd0 : d - 16'd1;
  endfunction

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign wr_req  = sel & wen[0] & (addr == 4'h0);
  assign rd_req  = sel & (wen == 4'b0000);
  assign clr_req = sel & wen[0] & (addr == 4'h4) & wdata[3];
  // A push to a full FIFO still lands if the FSM pops in the same cycle.
  assign push    = wr_req & (~full | pop);
  assign ovf_set = wr_req & full & ~pop;
  assign cnt7    = 7'(count_q);
  assign status  = {17'd0, cnt7, 4'd0, ovf_q, empty, full, (state_q != IDLE)};

  // Transmit FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    div_lat_d = div_lat_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          data_d    = mem_q[rd_ptr_q];
          div_lat_d = div_q;
          cnt_d     = reload(div_q);
          state_d   = START;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          state_d = DATA;
          bit_d   = 3'd0;
          cnt_d   = reload(div_lat_q);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = reload(div_lat_q);
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_q == 16'd0) begin
          state_d = STOP;
          cnt_d   = reload(div_lat_q);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == 16'd0) begin
          // Back-to-back frames: next start bit follows the stop bit directly.
          if (!empty) begin
            pop       = 1'b1;
            data_d    = mem_q[rd_ptr_q];
            div_lat_d = div_q;
            cnt_d     = reload(div_q);
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so it changes with the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = ^data_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO and register file
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    rdata_d  = rdata_q;

    if (push && !reset) mem_d[wr_ptr_q] = wdata[7:0];
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new overflow wins over a clear in the same cycle.
    if (ovf_set)      ovf_d = 1'b1;
    else if (clr_req) ovf_d = 1'b0;

    if (sel && addr == 4'h8) begin
      if (wen[0]) div_d[7:0]  = wdata[7:0];
      if (wen[1]) div_d[15:8] = wdata[15:8];
    end

    if (rd_req) begin
      case (addr)
        4'h4:    rdata_d = status;
        4'h8:    rdata_d = {16'd0, div_q};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      div_lat_q <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_q     <= DIV_RESET;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      div_lat_q <= div_lat_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = rdata_q;
  assign tx    = tx_q;
  assign irq   = empty & (state_q == IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
  localparam int          DEPTH = 8;
  localparam logic [15:0] DIVR  = 16'd434;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        tx, irq;

  always #5 clk = ~clk;

  mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIVR)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .wen(wen),
    .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model: byte queue plus the expected line waveform, one entry per cycle.
  logic [7:0]  mq[$];
  bit          wq[$];
  logic [15:0] m_div = DIVR;
  bit          m_ovf = 1'b0;
  logic [31:0] m_rd = 32'd0;

  typedef struct {
    logic [3:0]  addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Line level of frame bit k (0 = start, then data, [parity], stop).
  function automatic bit frame_lvl(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'd0;
    s[14:8] = 7'(mq.size());
    s[3] = m_ovf;
    s[2] = (mq.size() == 0);
    s[1] = (mq.size() == DEPTH);
    s[0] = (wq.size() != 0);
    return s;
  endfunction

  task automatic m_edge(input bit r, input bit s, input logic [3:0] a,
                        input logic [3:0] w, input logic [31:0] wd);
    bit pop_now, full_pre, ovf_set;
    logic [7:0] b;
    int n;
    if (r) begin
      mq.delete(); wq.delete();
      m_ovf = 1'b0; m_div = DIVR; m_rd = 32'd0;
      return;
    end
    if (s && w == 4'h0)
      m_rd = (a == 4'h4) ? m_status() : (a == 4'h8) ? {16'd0, m_div} : 32'd0;
    pop_now  = (mq.size() > 0) && (wq.size() <= 1);
    full_pre = (mq.size() == DEPTH);
    if (wq.size() > 0) void'(wq.pop_front());
    if (pop_now) begin
      b = mq.pop_front();
      n = (m_div == 16'd0) ? 1 : int'(m_div);
      for (int k = 0; k < NBITS; k++)
        for (int j = 0; j < n; j++) wq.push_back(frame_lvl(b, k));
    end
    ovf_set = 1'b0;
    if (s && w[0] && a == 4'h0) begin
      if (!full_pre || pop_now) mq.push_back(wd[7:0]);
      else ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (s && w[0] && a == 4'h4 && wd[3]) m_ovf = 1'b0;
    if (s && a == 4'h8) begin
      if (w[0]) m_div[7:0]  = wd[7:0];
      if (w[1]) m_div[15:8] = wd[15:8];
    end
  endtask

  // One clock: drive, advance the model at the edge, compare every output.
  task automatic step(input bit r, input bit s, input logic [3:0] a,
                      input logic [3:0] w, input logic [31:0] wd);
    reset = r; sel = s; addr = a; wen = w; wdata = wd;
    @(posedge clk);
    m_edge(r, s, a, w, wd);
    cyc++;
    #1;
    check1("tx", tx, (wq.size() > 0) ? wq[0] : 1'b1);
    check1("irq", irq, (mq.size() == 0) && (wq.size() == 0));
    check("rdata", rdata, m_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'h0, 4'h0, 32'd0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [3:0] w, input logic [31:0] d);
    step(0, 1, a, w, d);
  endtask
  task automatic rd(input logic [3:0] a);
    step(0, 1, a, 4'h0, 32'd0);
  endtask
  task automatic drain();
    int guard = 0;
    while ((wq.size() != 0 || mq.size() != 0) && guard < 20000) begin
      idle(1); guard++;
    end
    check("drain_timeout", guard, (guard < 20000) ? guard : 0);
    idle(2);
  endtask

  initial begin
    int n0, lows, r;
    logic [31:0] wd;

    tbl[0]  = '{4'h4, 4'h0, 32'h0,        32'h0000_0004};
    tbl[1]  = '{4'h8, 4'h0, 32'h0,        32'h0000_01B2};
    tbl[2]  = '{4'h0, 4'h0, 32'h0,        32'h0};
    tbl[3]  = '{4'hC, 4'h0, 32'h0,        32'h0};
    tbl[4]  = '{4'h8, 4'hF, 32'hDEAD_0003, 32'h0};
    tbl[5]  = '{4'h8, 4'h0, 32'h0,        32'h0000_0003};
    tbl[6]  = '{4'h8, 4'h2, 32'h0000_0100, 32'h0};
    tbl[7]  = '{4'h8, 4'h0, 32'h0,        32'h0000_0103};
    tbl[8]  = '{4'h8, 4'h1, 32'hFFFF_FF04, 32'h0};
    tbl[9]  = '{4'h8, 4'h0, 32'h0,        32'h0000_0104};
    tbl[10] = '{4'h8, 4'hC, 32'hFFFF_FFFF, 32'h0};
    tbl[11] = '{4'h8, 4'h0, 32'h0,        32'h0000_0104};
    tbl[12] = '{4'h2, 4'h0, 32'h0,        32'h0};

    // Reset state and register map
    step(1, 0, 4'h0, 4'h0, 32'd0);
    check1("rst_tx", tx, 1'b1);
    check1("rst_irq", irq, 1'b1);
    check("rst_rdata", rdata, 32'd0);
    for (int i = 0; i < 13; i++) begin
      step(0, 1, tbl[i].addr, tbl[i].wen, tbl[i].wdata);
      if (tbl[i].wen == 4'h0) check("tbl_rd", rdata, tbl[i].exp);
    end

    // DIV=4, 0x55: start at N+2..N+5, then 4-cycle bits, then irq
    step(1, 0, 4'h0, 4'h0, 32'd0);
    wr(4'h8, 4'h3, 32'd4);
    idle(2);
    wr(4'h0, 4'h1, 32'h55);
    n0 = cyc;
    check1("t55_c1", tx, 1'b1);
    for (int c = 2; c < 2 + 4 * NBITS; c++) begin
      idle(1);
      check1("t55_tx", tx, frame_lvl(8'h55, (c - 2) / 4));
      if (c == 2) check1("t55_busy_irq", irq, 1'b0);
    end
    idle(1);
    check1("t55_irq", irq, 1'b1);

    // Two queued bytes at DIV=2: no idle gap between frames
    wr(4'h8, 4'h1, 32'd2);
    idle(1);
    wr(4'h0, 4'h1, 32'hFF);
    n0 = cyc;
    wr(4'h0, 4'h1, 32'h00);
    while (cyc - n0 + 1 < 1 + 2 * NBITS) idle(1);
    check1("b2b_stop", tx, 1'b1);
    idle(1);
    check1("b2b_start", tx, 1'b0);
    drain();

    // DIV changed mid-frame: applies at the next pop
    wr(4'h8, 4'h1, 32'd4);
    idle(1);
    wr(4'h0, 4'h1, 32'hFF);
    n0 = cyc;
    idle(1);
    wr(4'h8, 4'h1, 32'd8);
    wr(4'h0, 4'h1, 32'h01);
    while (cyc - n0 + 1 < 2 + 4 * NBITS) idle(1);
    check1("div_f2_start", tx, 1'b0);
    idle(7);
    check1("div_f2_start_end", tx, 1'b0);
    idle(1);
    check1("div_f2_d0", tx, 1'b1);
    drain();

    // Overflow at DIV=1: 10 back-to-back writes, the last is dropped
    wr(4'h8, 4'h3, 32'd1);
    idle(1);
    for (int i = 0; i < 10; i++) wr(4'h0, 4'h1, 32'h10 + i);
    rd(4'h4);
    check("ovf_status", rdata, 32'h0000_080B);
    wr(4'h4, 4'h1, 32'h8);
    rd(4'h4);
    check1("ovf_clear", rdata[3], 1'b0);
    drain();

    // Reset mid-frame with bytes queued (bus write during reset is ignored)
    wr(4'h8, 4'h1, 32'd4);
    for (int i = 0; i < 3; i++) wr(4'h0, 4'h1, 32'h00);
    idle(8);
    step(1, 1, 4'h0, 4'h1, 32'hAA);
    check1("rst_mid_tx", tx, 1'b1);
    rd(4'h4);
    check("rst_mid_status", rdata, 32'h0000_0004);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      idle(1);
      if (tx == 1'b0) lows++;
    end
    check("rst_mid_quiet", lows, 0);

    // Randomized traffic against the model
    wr(4'h8, 4'h3, 32'd1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      wd = $urandom;
      if (r < 250) wr(4'h0, 4'($urandom_range(1, 15)) | 4'h1, wd);
      else if (r < 290) begin
        wd[15:8] = 8'h00;
        wd[7:0]  = 8'($urandom_range(0, 3));
        wr(4'h8, 4'($urandom_range(0, 15)), wd);
      end
      else if (r < 400) rd(4'($urandom_range(0, 15)));
      else if (r < 430) wr(4'h4, 4'h1, wd);
      else if (r < 480) step(0, 0, 4'h0, 4'hF, wd);
      else if (r < 483) step(1, 0, 4'h0, 4'h0, 32'd0);
      else idle(1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
